// File: rtl/regfile_wb_responder.sv
// Architectural register file and write-back responder: accepts one WB write per
// wb_active window, returns a sticky completion, bypasses reads and tracks RAW hazards.
module regfile_wb_responder #(
  parameter int              XLEN     = 64,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] SP_RESET = 64'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_wb_active,
  input  logic                  i_wr_en,
  input  logic [4:0]            i_wr_addr,
  input  logic [XLEN-1:0]       i_wr_data,
  output logic                  o_wr_complete,
  input  logic [4:0]            i_rs1_addr,
  input  logic [4:0]            i_rs2_addr,
  output logic [XLEN-1:0]       o_rs1_data,
  output logic [XLEN-1:0]       o_rs2_data,
  output logic                  o_rs1_busy,
  output logic                  o_rs2_busy,
  input  logic                  i_issue_valid,
  input  logic [4:0]            i_issue_rd,
  input  logic                  i_flush,
  output logic [NREGS*XLEN-1:0] o_regs_out
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

  logic [0:0]      r_state;
  logic [XLEN-1:0] r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busyNext;
  logic            w_accept;
  logic            w_commit;
  logic            w_rs1Bypass;
  logic            w_rs2Bypass;

  // Address 0 still completes the handshake but never touches the array.
  assign w_accept = (r_state == ST_IDLE) && i_wb_active && i_wr_en;
  assign w_commit = w_accept && (i_wr_addr != 5'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) r_state <= ST_DONE;
        ST_DONE: if (!i_wb_active) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_wr_complete = (r_state == ST_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= (i == 2) ? SP_RESET : '0;
      end
    end else if (w_commit) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  // Priority low to high: commit clear, issue set (newer producer wins), flush.
  always_comb begin
    w_busyNext = r_busy;
    if (w_commit) w_busyNext[i_wr_addr] = 1'b0;
    if (i_issue_valid && (i_issue_rd != 5'd0)) w_busyNext[i_issue_rd] = 1'b1;
    if (i_flush) w_busyNext = '0;
    w_busyNext[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_busy <= '0;
    else       r_busy <= w_busyNext;
  end

  assign w_rs1Bypass = w_accept && (i_wr_addr == i_rs1_addr) && (i_rs1_addr != 5'd0);
  assign w_rs2Bypass = w_accept && (i_wr_addr == i_rs2_addr) && (i_rs2_addr != 5'd0);

  always_comb begin
    o_rs1_data = '0;
    o_rs2_data = '0;
    if (w_rs1Bypass)             o_rs1_data = i_wr_data;
    else if (i_rs1_addr != 5'd0) o_rs1_data = r_regs[i_rs1_addr];
    if (w_rs2Bypass)             o_rs2_data = i_wr_data;
    else if (i_rs2_addr != 5'd0) o_rs2_data = r_regs[i_rs2_addr];
  end

  assign o_rs1_busy = w_rs1Bypass ? 1'b0 : r_busy[i_rs1_addr];
  assign o_rs2_busy = w_rs2Bypass ? 1'b0 : r_busy[i_rs2_addr];

  always_comb begin
    o_regs_out = '0;
    for (int i = 0; i < NREGS; i++) begin
      o_regs_out[i*XLEN +: XLEN] = r_regs[i];
    end
  end

endmodule

// File: tb/tb_regfile_wb_responder.sv
// Bench for regfile_wb_responder: a cycle-by-cycle vector table plus hand-written
// sequences for write-once, async reset in DONE and array contents.
module tb_regfile_wb_responder;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;

  typedef struct {
    logic        wbActive;
    logic        wrEn;
    logic [4:0]  wrAddr;
    logic [63:0] wrData;
    logic [4:0]  rs1Addr;
    logic [4:0]  rs2Addr;
    logic        issueValid;
    logic [4:0]  issueRd;
    logic        flush;
    logic [63:0] expRs1Data;
    logic [63:0] expRs2Data;
    logic        expRs1Busy;
    logic        expRs2Busy;
    logic        expComplete;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic wbActive, wrEn, issueValid, flush;
  logic [4:0] wrAddr, rs1Addr, rs2Addr, issueRd;
  logic [63:0] wrData, rs1Data, rs2Data;
  logic rs1Busy, rs2Busy, wrComplete;
  logic [NREGS*XLEN-1:0] regsOut;

  int testsRun = 0;
  int testsFailed = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  regfile_wb_responder #(.XLEN(XLEN), .NREGS(NREGS), .SP_RESET(64'h8000)) dut (
    .clk(clk), .reset(reset),
    .i_wb_active(wbActive), .i_wr_en(wrEn), .i_wr_addr(wrAddr), .i_wr_data(wrData),
    .o_wr_complete(wrComplete),
    .i_rs1_addr(rs1Addr), .i_rs2_addr(rs2Addr),
    .o_rs1_data(rs1Data), .o_rs2_data(rs2Data),
    .o_rs1_busy(rs1Busy), .o_rs2_busy(rs2Busy),
    .i_issue_valid(issueValid), .i_issue_rd(issueRd), .i_flush(flush),
    .o_regs_out(regsOut)
  );

  function automatic vec_t mk(logic wb, logic en, logic [4:0] addr, logic [63:0] data,
                              logic [4:0] r1, logic [4:0] r2, logic iv, logic [4:0] ird,
                              logic fl, logic [63:0] e1, logic [63:0] e2,
                              logic eb1, logic eb2, logic ec);
    vec_t v;
    v.wbActive = wb;  v.wrEn = en;   v.wrAddr = addr;  v.wrData = data;
    v.rs1Addr = r1;   v.rs2Addr = r2; v.issueValid = iv; v.issueRd = ird;
    v.flush = fl;     v.expRs1Data = e1; v.expRs2Data = e2;
    v.expRs1Busy = eb1; v.expRs2Busy = eb2; v.expComplete = ec;
    return v;
  endfunction

  function automatic logic [63:0] getReg(int idx);
    return regsOut[idx*XLEN +: XLEN];
  endfunction

  task automatic applyStimulus(input vec_t v);
    wbActive = v.wbActive; wrEn = v.wrEn; wrAddr = v.wrAddr; wrData = v.wrData;
    rs1Addr = v.rs1Addr; rs2Addr = v.rs2Addr;
    issueValid = v.issueValid; issueRd = v.issueRd; flush = v.flush;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(mk(0,0,0,0, 2,7, 0,0,0, 0,0,0,0,0));
    reset = 1'b1;
    #12;
    for (int i = 0; i < NREGS; i++) begin
      checkOutput($sformatf("reset x%0d", i), getReg(i), (i == 2) ? 64'h8000 : 64'h0);
    end
    checkOutput("reset complete", {63'd0, wrComplete}, 64'd0);
    checkOutput("reset rs1Busy", {63'd0, rs1Busy}, 64'd0);
    checkOutput("reset rs2Busy", {63'd0, rs2Busy}, 64'd0);
    nextCycle();
    reset = 1'b0;

    //                 wb en addr data          r1  r2  iv ird fl  expRs1        expRs2        b1 b2 cmp
    vecs.push_back(mk(0,0, 0, 64'h0,          2,  0,  0, 0, 0, 64'h8000,     64'h0,        0,0,0));
    vecs.push_back(mk(1,1, 5, 64'hDEAD_BEEF,  5,  2,  0, 0, 0, 64'hDEAD_BEEF,64'h8000,     0,0,0));
    vecs.push_back(mk(1,1, 5, 64'hDEAD_BEEF,  5,  2,  0, 0, 0, 64'hDEAD_BEEF,64'h8000,     0,0,1));
    vecs.push_back(mk(1,1, 5, 64'hDEAD_BEEF,  5,  2,  0, 0, 0, 64'hDEAD_BEEF,64'h8000,     0,0,1));
    vecs.push_back(mk(0,0, 0, 64'h0,          5,  0,  0, 0, 0, 64'hDEAD_BEEF,64'h0,        0,0,1));
    vecs.push_back(mk(0,0, 0, 64'h0,          5,  0,  0, 0, 0, 64'hDEAD_BEEF,64'h0,        0,0,0));
    vecs.push_back(mk(1,1, 0, 64'h1234,       0,  0,  0, 0, 0, 64'h0,        64'h0,        0,0,0));
    vecs.push_back(mk(1,1, 0, 64'h1234,       0,  0,  0, 0, 0, 64'h0,        64'h0,        0,0,1));
    vecs.push_back(mk(0,0, 0, 64'h0,          0,  0,  0, 0, 0, 64'h0,        64'h0,        0,0,1));
    vecs.push_back(mk(0,0, 0, 64'h0,          0,  0,  0, 0, 0, 64'h0,        64'h0,        0,0,0));
    vecs.push_back(mk(0,0, 0, 64'h0,          7,  7,  1, 7, 0, 64'h0,        64'h0,        0,0,0));
    vecs.push_back(mk(0,0, 0, 64'h0,          7,  7,  0, 0, 0, 64'h0,        64'h0,        1,1,0));
    vecs.push_back(mk(1,1, 7, 64'h77,         7,  3,  0, 0, 0, 64'h77,       64'h0,        0,0,0));
    vecs.push_back(mk(1,1, 7, 64'h77,         7,  3,  0, 0, 0, 64'h77,       64'h0,        0,0,1));
    vecs.push_back(mk(0,0, 0, 64'h0,          7,  3,  0, 0, 0, 64'h77,       64'h0,        0,0,1));
    vecs.push_back(mk(0,0, 0, 64'h0,          7,  3,  1, 7, 0, 64'h77,       64'h0,        0,0,0));
    vecs.push_back(mk(1,1, 7, 64'h99,         7,  7,  1, 7, 0, 64'h99,       64'h99,       0,0,0));
    vecs.push_back(mk(1,1, 7, 64'h99,         7,  7,  0, 0, 0, 64'h99,       64'h99,       1,1,1));
    vecs.push_back(mk(0,0, 0, 64'h0,          7,  7,  0, 0, 0, 64'h99,       64'h99,       1,1,1));
    vecs.push_back(mk(0,0, 0, 64'h0,          7,  9,  1, 9, 1, 64'h99,       64'h0,        1,0,0));
    vecs.push_back(mk(0,0, 0, 64'h0,          7,  9,  0, 0, 0, 64'h99,       64'h0,        0,0,0));
    for (int i = 0; i < 4; i++) begin
      vecs.push_back(mk(1,0,10, 64'h2A,      10,  0,  0, 0, 0, 64'h0,        64'h0,        0,0,0));
    end
    vecs.push_back(mk(1,1,10, 64'h2A,        10,  0,  0, 0, 0, 64'h2A,       64'h0,        0,0,0));
    vecs.push_back(mk(1,1,10, 64'h2A,        10,  0,  0, 0, 0, 64'h2A,       64'h0,        0,0,1));
    vecs.push_back(mk(0,0, 0, 64'h0,         10,  5,  0, 0, 0, 64'h2A,       64'hDEAD_BEEF,0,0,1));
    vecs.push_back(mk(0,0, 0, 64'h0,         10,  5,  1, 0, 0, 64'h2A,       64'hDEAD_BEEF,0,0,0));
    vecs.push_back(mk(0,0, 0, 64'h0,          0,  5,  1,12, 0, 64'h0,        64'hDEAD_BEEF,0,0,0));
    vecs.push_back(mk(1,1,12, 64'hC,         12,  0,  0, 0, 1, 64'hC,        64'h0,        0,0,0));
    vecs.push_back(mk(1,1,12, 64'hC,         12,  0,  0, 0, 0, 64'hC,        64'h0,        0,0,1));
    vecs.push_back(mk(0,0, 0, 64'h0,         12,  0,  0, 0, 0, 64'hC,        64'h0,        0,0,1));
    vecs.push_back(mk(0,0, 0, 64'h0,         12,  0,  0, 0, 0, 64'hC,        64'h0,        0,0,0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("v%0d rs1Data", i), rs1Data, vecs[i].expRs1Data);
      checkOutput($sformatf("v%0d rs2Data", i), rs2Data, vecs[i].expRs2Data);
      checkOutput($sformatf("v%0d rs1Busy", i), {63'd0, rs1Busy}, {63'd0, vecs[i].expRs1Busy});
      checkOutput($sformatf("v%0d rs2Busy", i), {63'd0, rs2Busy}, {63'd0, vecs[i].expRs2Busy});
      checkOutput($sformatf("v%0d complete", i), {63'd0, wrComplete}, {63'd0, vecs[i].expComplete});
      nextCycle();
    end

    checkOutput("array x0", getReg(0), 64'h0);
    checkOutput("array x5", getReg(5), 64'hDEAD_BEEF);
    checkOutput("array x7", getReg(7), 64'h99);
    checkOutput("array x10", getReg(10), 64'h2A);
    checkOutput("array x12", getReg(12), 64'hC);

    // Changing data while DONE must not produce a second write.
    applyStimulus(mk(1,1,6,64'hAAAA, 6,0, 0,0,0, 0,0,0,0,0));
    nextCycle();
    wrData = 64'hBBBB;
    nextCycle();
    nextCycle();
    checkOutput("once x6", getReg(6), 64'hAAAA);
    checkOutput("once complete", {63'd0, wrComplete}, 64'd1);
    wbActive = 1'b0; wrEn = 1'b0;
    nextCycle();
    checkOutput("once drop", {63'd0, wrComplete}, 64'd0);

    // Reset while DONE clears completion with no clock edge.
    applyStimulus(mk(1,1,3,64'h33, 3,0, 0,0,0, 0,0,0,0,0));
    nextCycle();
    checkOutput("pre-reset complete", {63'd0, wrComplete}, 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("async complete", {63'd0, wrComplete}, 64'd0);
    checkOutput("async x3", getReg(3), 64'h0);
    checkOutput("async x5", getReg(5), 64'h0);
    checkOutput("async x2", getReg(2), 64'h8000);
    wbActive = 1'b0; wrEn = 1'b0;
    nextCycle();
    reset = 1'b0;
    applyStimulus(mk(1,1,3,64'h33, 3,0, 0,0,0, 0,0,0,0,0));
    @(negedge clk);
    checkOutput("post-reset idle", {63'd0, wrComplete}, 64'd0);
    checkOutput("post-reset bypass", rs1Data, 64'h33);
    nextCycle();
    checkOutput("post-reset complete", {63'd0, wrComplete}, 64'd1);
    checkOutput("post-reset x3", getReg(3), 64'h33);
    wbActive = 1'b0; wrEn = 1'b0;
    nextCycle();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
